trace_capture: RTL and testbench
================================

# trace_capture

Parametrised retire-trace capture buffer for the single-cycle RV32I core. It records one multi-channel sample per retiring instruction (PC, instruction, ALU result, write-back) into an on-chip ring, either until full or around a PC trigger. It then drains the stored entries oldest-first over a valid/ready stream. It sits beside `top` and replaces cycle-by-cycle simulator printing with hardware capture usable on FPGA.

## Interface
- `XLEN`, 32, width of one channel.
- `DEPTH`, 64, entries held; power of two, ≥ 4.
- `NUM_CH`, 4, channels per sample; channel 0 is always PC.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `arm`  in  1  single-cycle pulse; clears buffer and starts capture from any state.
- `mode`  in  1  sampled on `arm`: 0 = FILL, 1 = TRIG.
- `trig_pc`  in  XLEN  sampled on `arm`: PC value that fires the trigger.
- `post_cnt`  in  $clog2(DEPTH)+1  sampled on `arm`: samples stored after the trigger sample; values above DEPTH−1 are clamped to DEPTH−1.
- `smp_valid`  in  1  one retiring instruction this cycle.
- `smp_data`  in  NUM_CH*XLEN  channel k at bits [k*XLEN +: XLEN].
- `out_valid`  out  1  entry presented.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  NUM_CH*XLEN  stored sample.
- `out_last`  out  1  qualifies the final entry.
- `busy`  out  1  state is CAPTURE.
- `done`  out  1  state is DRAIN.
- `count`  out  $clog2(DEPTH)+1  entries currently held.
- `triggered`  out  1  trigger has fired since the last `arm`.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE → CAPTURE on `arm`. `arm` in CAPTURE or DRAIN restarts: pointers, `count`, `triggered` and wrap flag are cleared, and the in-progress drain is abandoned.
- CAPTURE: each cycle with `smp_valid`, write `smp_data` at `wr_ptr`, increment `wr_ptr` modulo DEPTH, and saturate `count` at DEPTH. A wrap sets the internal `wrapped` flag.
- FILL mode: CAPTURE → DRAIN on the write that makes `count` == DEPTH. No wrap occurs.
- TRIG mode: the buffer is circular. While not yet triggered, the trigger fires on the first stored sample with channel 0 == `trig_pc`. That sample is stored, `triggered` is set, and `remain` is loaded with the clamped `post_cnt`.
  - Each later stored sample decrements `remain`.
  - CAPTURE → DRAIN on the store that leaves `remain` == 0. With `post_cnt` = 0, this is the trigger sample itself.
- DRAIN:
  - `rd_ptr` starts at `wr_ptr` if `wrapped`, else 0.
  - On `out_valid && out_ready`: advance `rd_ptr` modulo DEPTH and decrement `count`.
  - `out_last` = (`count` == 1).
  - After the last transfer, DRAIN → IDLE.
  - `smp_valid` is ignored in DRAIN and IDLE.
- An `arm` and `smp_valid` in the same cycle: `arm` wins, and that sample is not stored.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `out_data` 0, `busy` 0, `done` 0, `count` 0, `triggered` 0; pointers, `remain` and `wrapped` 0.
- Capture latency: a sample presented in cycle n is in memory and reflected in `count` after edge n.
- `out_valid` rises the cycle after entering DRAIN and stays high until the last transfer.
- `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- Back-to-back transfers run at one per cycle with `out_ready` held high.
- `out_valid` drops in the cycle after the last transfer.
- Reset asserted mid-capture or mid-drain forces reset values immediately. Memory contents are not cleared and are never exposed, because `count` is 0.

## Structure
- Package `trace_pkg` holds:
  - state enum `trace_state_e` {IDLE, CAPTURE, DRAIN};
  - mode enum {MODE_FILL, MODE_TRIG};
  - channel index constants CH_PC = 0, CH_INSTR = 1, CH_ALU = 2, CH_WB = 3.
- Sub-module `trace_ram`: DEPTH × (NUM_CH*XLEN) flop array with one synchronous write port and one asynchronous read port; no reset on the array.

## Test plan
- FILL, DEPTH = 8, NUM_CH = 2; 8 samples {PC = 0x0,0x4,…,0x1C} with gaps in `smp_valid` → `done` after the 8th; drain with `out_ready` = 1 yields 8 entries in order, `out_last` on PC 0x1C, then IDLE with `count` 0.
- TRIG, DEPTH = 8, `trig_pc` = 0x40, `post_cnt` = 2, PCs 0x0…0x60 step 4 → capture stops after PC 0x48; drain outputs PCs 0x2C…0x48 (8 entries, wrapped).
- TRIG with `post_cnt` = 0 → drain after the trigger sample; last entry PC = `trig_pc`; `triggered` = 1.
- Drain with `out_ready` toggling 1,0,0,1… → no entry lost or duplicated; data stable while stalled.
- `reset` pulsed low mid-capture → all outputs at reset values within the same cycle; a new `arm` captures normally.
- `arm` during DRAIN after 3 transfers → `count` 0, `out_valid` 0 next cycle, capture restarts.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the retire-trace capture buffer: FSM states, capture modes
// and the channel layout of one sample.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } trace_state_e;

  typedef enum logic {
    MODE_FILL,
    MODE_TRIG
  } trace_mode_e;

  typedef enum int unsigned {
    CH_PC    = 0,
    CH_INSTR = 1,
    CH_ALU   = 2,
    CH_WB    = 3
  } trace_ch_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: flop array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Retire-trace capture buffer: records per-instruction samples into a ring
// (fill-until-full or around a PC trigger), then drains them oldest-first.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   mode,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic [$clog2(DEPTH):0] post_cnt,
  input  logic                   smp_valid,
  input  logic [NUM_CH*XLEN-1:0] smp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*XLEN-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   triggered
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned W      = NUM_CH * XLEN;
  localparam int unsigned PC_LSB = XLEN * CH_PC;

  trace_state_e      state_q, state_d;
  trace_mode_e       mode_q;
  logic [XLEN-1:0]   trig_pc_q;
  logic [AW-1:0]     post_q, post_clamp;
  logic [AW-1:0]     wr_ptr, rd_ptr, remain;
  logic [CW-1:0]     count_q;
  logic              wrapped, trig_q, out_valid_q;
  logic [W-1:0]      rd_data;

  logic              store, hit, cap_end, store_end, xfer;
  logic [AW-1:0]     wr_ptr_nx;
  logic              wrap_nx;

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(W)
  ) u_ram (
    .clk  (clk),
    .we   (store),
    .waddr(wr_ptr),
    .wdata(smp_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_comb begin
    post_clamp = (post_cnt > CW'(DEPTH - 1)) ? AW'(DEPTH - 1) : post_cnt[AW-1:0];
    store      = (state_q == CAPTURE) && smp_valid && !arm;
    hit        = store && (mode_q == MODE_TRIG) && !trig_q &&
                 (smp_data[PC_LSB +: XLEN] == trig_pc_q);
    xfer       = out_valid_q && out_ready && !arm;
    wr_ptr_nx  = wr_ptr + AW'(1);
    wrap_nx    = wrapped | (wr_ptr == AW'(DEPTH - 1));
    if (mode_q == MODE_FILL) cap_end = (count_q == CW'(DEPTH - 1));
    else if (hit)            cap_end = (post_q == '0);
    else                     cap_end = trig_q && (remain == AW'(1));
    store_end  = store && cap_end;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: if (store_end) state_d = DRAIN;
        DRAIN:   if (xfer && count_q == CW'(1)) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_FILL;
      trig_pc_q   <= '0;
      post_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      remain      <= '0;
      count_q     <= '0;
      wrapped     <= 1'b0;
      trig_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (arm) begin
      mode_q      <= trace_mode_e'(mode);
      trig_pc_q   <= trig_pc;
      post_q      <= post_clamp;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      remain      <= '0;
      count_q     <= '0;
      wrapped     <= 1'b0;
      trig_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr  <= wr_ptr_nx;
        wrapped <= wrap_nx;
        if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
        if (hit) begin
          trig_q <= 1'b1;
          remain <= post_q;
        end else if (trig_q) begin
          remain <= remain - AW'(1);
        end
        // Oldest entry sits just past the final write once the ring has wrapped.
        if (store_end) rd_ptr <= wrap_nx ? wr_ptr_nx : '0;
      end
      if (xfer) begin
        rd_ptr  <= rd_ptr + AW'(1);
        count_q <= count_q - CW'(1);
      end
      out_valid_q <= (state_q == DRAIN) && (state_d == DRAIN);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? rd_data : '0;
  assign out_last  = out_valid_q && (count_q == CW'(1));
  assign busy      = (state_q == CAPTURE);
  assign done      = (state_q == DRAIN);
  assign count     = count_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DEPTH=8, two channels).
module tb_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [3:0]  post_cnt = '0;
  logic        smp_valid = 1'b0;
  logic [63:0] smp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic        triggered;

  int tests = 0;
  int fails = 0;

  trace_capture #(
    .XLEN  (32),
    .DEPTH (8),
    .NUM_CH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .mode     (mode),
    .trig_pc  (trig_pc),
    .post_cnt (post_cnt),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [31:0] tpc, input logic [3:0] pc_post);
    arm = 1'b1; mode = m; trig_pc = tpc; post_cnt = pc_post;
    step;
    arm = 1'b0; mode = ~m; trig_pc = '1; post_cnt = '0;
  endtask

  task automatic feed(input logic [31:0] pc);
    smp_valid = 1'b1;
    smp_data  = mk(pc);
    step;
    smp_valid = 1'b0;
  endtask

  // Drain n entries expected at PCs first_pc, first_pc+4, ...; optionally
  // throttle with ready high one cycle in three.
  task automatic drain(input logic [31:0] first_pc, input int n, input bit toggle);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [63:0] held = '0;
    logic [31:0] pc;
    while (got < n && cyc < 200) begin
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (stalled) check("stall_data", out_data, held);
      if (out_valid && out_ready) begin
        pc = first_pc + 32'(4 * got);
        check("drain_data", out_data, mk(pc));
        check("drain_last", out_last, got == n - 1);
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      step;
      cyc++;
    end
    check("drain_entries", got, n);
    out_ready = 1'b0;
    check("post_drain_valid", out_valid, 0);
    check("post_drain_done", done, 0);
    check("post_drain_count", count, 0);
  endtask

  initial begin
    int got;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_trig", triggered, 0);
    reset = 1'b1;
    step;

    // FILL: 8 samples with gaps, then a full-rate drain
    do_arm(1'b0, 32'h0, 4'd0);
    check("fill_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      feed(32'(4 * i));
      check("fill_count", count, i + 1);
      check("fill_done", done, i == 7);
      if (i < 7 && (i % 2) == 1) step;
    end
    check("fill_busy_end", busy, 0);
    check("fill_first_valid", out_valid, 0);
    drain(32'h0, 8, 1'b0);
    check("fill_idle_busy", busy, 0);

    // TRIG: trigger at 0x40, two post samples, ring wraps
    do_arm(1'b1, 32'h40, 4'd2);
    for (int i = 0; i <= 24; i++) begin
      feed(32'(4 * i));
      if (i == 15) check("trig_before", triggered, 0);
      if (i == 16) check("trig_fire", triggered, 1);
      if (i == 16) check("trig_sat_count", count, 8);
      if (i == 17) check("trig_not_done", done, 0);
      if (i == 18) check("trig_done", done, 1);
    end
    check("trig_ignore_count", count, 8);
    drain(32'h2C, 8, 1'b0);

    // TRIG, post_cnt 0, throttled drain
    do_arm(1'b1, 32'h10, 4'd0);
    for (int i = 0; i <= 4; i++) feed(32'(4 * i));
    check("p0_done", done, 1);
    check("p0_trig", triggered, 1);
    check("p0_count", count, 5);
    drain(32'h0, 5, 1'b1);

    // post_cnt above DEPTH-1 clamps to 7
    do_arm(1'b1, 32'h8, 4'd15);
    for (int i = 0; i <= 9; i++) begin
      feed(32'(4 * i));
      check("clamp_done", done, i == 9);
    end
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (out_valid) begin
        check("abort_data", out_data, mk(32'h8 + 32'(4 * got)));
        got++;
      end
      step;
    end
    check("abort_count_pre", count, 5);

    // arm during drain, with a colliding sample that must be dropped
    arm = 1'b1; mode = 1'b0; smp_valid = 1'b1; smp_data = mk(32'h200);
    step;
    arm = 1'b0; smp_valid = 1'b0; out_ready = 1'b0;
    check("abort_count", count, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_trig", triggered, 0);

    // asynchronous reset mid-capture
    feed(32'h300);
    feed(32'h304);
    check("pre_rst_count", count, 2);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    #1 reset = 1'b1;
    step;
    do_arm(1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 8; i++) feed(32'h100 + 32'(4 * i));
    check("re_done", done, 1);
    drain(32'h100, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
